imem_loader: RTL

//  Boot-time program writer for the single-cycle CPU's instruction memory. Takes a

---
 rtl/imem_loader_pkg.sv | 13 +
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_loader_timer.sv | 26 ++
 rtl/imem_loader.sv | 110 +++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encodings and default program capacity.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    LD_LOAD = 2'd0,
    LD_HOLD = 2'd1,
    LD_RUN  = 2'd2
  } ld_state_e;

  localparam int DEF_PROG_WORDS = 256;

endpackage

// File: rtl/imem_loader_if.sv
// Valid/ready word stream from the host into the loader; in_last marks the
// final program word.
interface imem_loader_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/imem_loader_timer.sv
// Down-counter that keeps the CPU in reset for a fixed number of cycles after
// the final write; expired goes high once the loaded count has drained.
module imem_loader_timer #(
  parameter int HOLD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expired
);
  localparam int CNT_W = $clog2(HOLD + 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= CNT_W'(HOLD);
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign expired = (cnt_reg == '0);
endmodule

// File: rtl/imem_loader.sv
// Boot-time writer for the CPU instruction memory: streams host words into
// consecutive imem addresses while holding the CPU in reset, then releases it.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int PROG_WORDS = DEF_PROG_WORDS,
  parameter int RESET_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  imem_loader_if.slave      host,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic [ADDR_W:0]   words_loaded,
  output logic              err_overflow
);
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(PROG_WORDS - 1);

  ld_state_e       state_reg, state_next;
  logic [ADDR_W:0] wr_ptr_reg;
  logic            accept;
  logic            at_limit;
  logic            hold_load;
  logic            hold_expired;

  assign host.in_ready = (state_reg == LD_LOAD);
  assign accept        = host.in_valid & host.in_ready;
  assign at_limit      = (wr_ptr_reg == LAST_PTR);
  assign words_loaded  = wr_ptr_reg;

  imem_loader_timer #(
    .HOLD (RESET_HOLD)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (hold_load),
    .expired (hold_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= LD_LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  // The timer is armed on the final accept so HOLD spans RESET_HOLD+1 edges.
  always_comb begin
    state_next = state_reg;
    hold_load  = 1'b0;
    case (state_reg)
      LD_LOAD: begin
        if (accept && (host.in_last || at_limit)) begin
          state_next = LD_HOLD;
          hold_load  = 1'b1;
        end
      end
      LD_HOLD: begin
        if (hold_expired) begin
          state_next = LD_RUN;
        end
      end
      LD_RUN: begin
        if (reload) begin
          state_next = LD_LOAD;
        end
      end
      default: state_next = LD_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      wr_ptr_reg   <= '0;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      imem_we <= accept;
      if (accept) begin
        imem_addr  <= wr_ptr_reg[ADDR_W-1:0];
        imem_wdata <= host.in_data;
        wr_ptr_reg <= wr_ptr_reg + (ADDR_W + 1)'(1);
      end
      // A full memory without in_last means the host program was truncated.
      if (accept && at_limit && !host.in_last) begin
        err_overflow <= 1'b1;
      end
      if (state_reg == LD_HOLD && hold_expired) begin
        cpu_rst <= 1'b0;
        done    <= 1'b1;
      end
      if (state_reg == LD_RUN && reload) begin
        cpu_rst    <= 1'b1;
        done       <= 1'b0;
        wr_ptr_reg <= '0;
      end
    end
  end
endmodule
